// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the data-RAM arbiter: access width codes, read-owner tags,
// burst sequencer states and width helpers.
package riscv_bus_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'd0;
   localparam logic [1:0] WIDTH_HALF = 2'd1;
   localparam logic [1:0] WIDTH_WORD = 2'd2;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_CORE = 2'd1,
      RD_DMA  = 2'd2
   } rd_owner_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_t;

   // The reserved code 3 behaves as a word access.
   function automatic logic [1:0] norm_width(input logic [1:0] width);
      logic [1:0] result;
      case (width)
         WIDTH_BYTE: result = WIDTH_BYTE;
         WIDTH_HALF: result = WIDTH_HALF;
         default:    result = WIDTH_WORD;
      endcase
      return result;
   endfunction

   function automatic logic [31:0] width_step(input logic [1:0] width);
      logic [31:0] result;
      case (norm_width(width))
         WIDTH_BYTE: result = 32'd1;
         WIDTH_HALF: result = 32'd2;
         default:    result = 32'd4;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/riscv_arb_burst_seq.sv
// DMA burst sequencer for riscv_mem_arbiter (used only when ARB_BURST_EN is defined):
// tracks beats of a multi-beat DMA request and generates the per-beat address.
module riscv_arb_burst_seq
   import riscv_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        dma_req,
   input  logic [31:0] dma_address,
   input  logic [1:0]  dma_width,
   input  logic [3:0]  dma_len,
   input  logic        gnt,
   output logic        beat_valid,
   output logic [31:0] beat_address,
   output logic [1:0]  beat_width,
   output logic        beat_last
);

   burst_state_t state_r, state_s;
   logic [31:0]  addr_r, addr_s;
   logic [3:0]   len_r, len_s;
   logic [3:0]   beat_r, beat_s;
   logic [1:0]   width_r, width_s;

   // A burst can only continue while the master keeps its request up.
   assign beat_valid = dma_req;

   // State, latched burst fields and beat index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         addr_r  <= 32'd0;
         len_r   <= 4'd0;
         beat_r  <= 4'd0;
         width_r <= 2'd0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         len_r   <= len_s;
         beat_r  <= beat_s;
         width_r <= width_s;
      end
   end

   // Current beat presented to the arbiter: live request fields when idle, latched ones in a burst.
   always_comb begin
      beat_address = dma_address;
      beat_width   = norm_width(dma_width);
      beat_last    = (dma_len == 4'd0);
      case (state_r)
         ST_IDLE: begin
            beat_address = dma_address;
            beat_width   = norm_width(dma_width);
            beat_last    = (dma_len == 4'd0);
         end
         ST_BURST: begin
            beat_address = addr_r;
            beat_width   = width_r;
            beat_last    = (beat_r == len_r);
         end
         default: begin
            beat_address = dma_address;
            beat_width   = norm_width(dma_width);
            beat_last    = (dma_len == 4'd0);
         end
      endcase
   end

   // Next-state: enter a burst on the first granted beat, step per grant, abort on dropped request.
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      len_s   = len_r;
      beat_s  = beat_r;
      width_s = width_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt && (dma_len != 4'd0)) begin
               state_s = ST_BURST;
               addr_s  = dma_address + width_step(dma_width);
               len_s   = dma_len;
               beat_s  = 4'd1;
               width_s = norm_width(dma_width);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (!dma_req) begin
               state_s = ST_IDLE;
            end else if (gnt && beat_last) begin
               state_s = ST_IDLE;
            end else if (gnt) begin
               addr_s = addr_r + width_step(width_r);
               beat_s = beat_r + 4'd1;
            end else begin
               state_s = ST_BURST;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Core/DMA arbiter in front of the single-port data RAM; the core always wins, DMA uses idle cycles.
// Multi-beat DMA bursts are compiled in with the ARB_BURST_EN macro.
module riscv_mem_arbiter
   import riscv_bus_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 16,
   parameter int unsigned CNT_W        = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] core_address,
   input  logic [1:0]  core_width,
   input  logic [31:0] core_wdata,
   input  logic        core_read,
   input  logic        core_write,
   output logic [31:0] core_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_address,
   input  logic [1:0]  dma_width,
   input  logic [3:0]  dma_len,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic        dma_starve,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_width,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);

   logic         core_active_s;
   logic         beat_valid_s;
   logic [31:0]  beat_address_s;
   logic [1:0]   beat_width_s;
   logic         beat_last_s;
   rd_owner_t    rd_owner_s, rd_owner_r;
   logic [CNT_W-1:0] cnt_s, cnt_r;
   logic         starve_r;
   logic [31:0]  dma_rdata_r;

   assign core_active_s = core_read | core_write;

`ifdef ARB_BURST_EN
   riscv_arb_burst_seq u_burst_seq (
      .clock        (clock),
      .reset        (reset),
      .dma_req      (dma_req),
      .dma_address  (dma_address),
      .dma_width    (dma_width),
      .dma_len      (dma_len),
      .gnt          (dma_gnt),
      .beat_valid   (beat_valid_s),
      .beat_address (beat_address_s),
      .beat_width   (beat_width_s),
      .beat_last    (beat_last_s)
   );
`else
   logic unused_len_s;
   assign unused_len_s   = ^dma_len;
   assign beat_valid_s   = dma_req;
   assign beat_address_s = dma_address;
   assign beat_width_s   = norm_width(dma_width);
   assign beat_last_s    = 1'b1;
`endif

   // RAM port mux: reset or no requester leaves the RAM idle with all fields zero.
   always_comb begin
      mem_address = 32'd0;
      mem_width   = 2'd0;
      mem_wdata   = 32'd0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      dma_gnt     = 1'b0;
      rd_owner_s  = RD_NONE;
      if (reset) begin
         rd_owner_s = RD_NONE;
      end else if (core_active_s) begin
         mem_address = core_address;
         mem_width   = core_width;
         mem_wdata   = core_wdata;
         mem_write   = core_write;
         mem_read    = core_read & ~core_write;
         rd_owner_s  = (core_read & ~core_write) ? RD_CORE : RD_NONE;
      end else if (beat_valid_s) begin
         mem_address = beat_address_s;
         mem_width   = beat_width_s;
         mem_wdata   = dma_wdata;
         mem_write   = dma_we;
         mem_read    = ~dma_we;
         dma_gnt     = 1'b1;
         rd_owner_s  = dma_we ? RD_NONE : RD_DMA;
      end else begin
         rd_owner_s = RD_NONE;
      end
   end

   assign dma_done = dma_gnt & beat_last_s;

   // Starvation wait counter: counts denied request cycles, saturating.
   always_comb begin
      cnt_s = cnt_r;
      if (dma_req && !dma_gnt) begin
         cnt_s = (cnt_r == CNT_MAX_C) ? cnt_r : (cnt_r + CNT_ONE_C);
      end else begin
         cnt_s = {CNT_W{1'b0}};
      end
   end

   // Read ownership, wait counter, starve flag and held DMA read data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_owner_r  <= RD_NONE;
         cnt_r       <= {CNT_W{1'b0}};
         starve_r    <= 1'b0;
         dma_rdata_r <= 32'd0;
      end else begin
         rd_owner_r <= rd_owner_s;
         cnt_r      <= cnt_s;
         starve_r   <= (cnt_s >= STARVE_LIM_C);
         if (rd_owner_r == RD_DMA) begin
            dma_rdata_r <= mem_rdata;
         end else begin
            dma_rdata_r <= dma_rdata_r;
         end
      end
   end

   // The RAM output is already a register, so DMA data is bypassed in its valid cycle and held after.
   assign dma_rvalid = (rd_owner_r == RD_DMA);
   assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_r;
   assign dma_starve = starve_r;
   assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Burst scenarios are exercised when ARB_BURST_EN is defined.
module tb_riscv_mem_arbiter;

   logic        clock;
   logic        reset;
   logic [31:0] core_address;
   logic [1:0]  core_width;
   logic [31:0] core_wdata;
   logic        core_read;
   logic        core_write;
   logic [31:0] core_rdata;
   logic        dma_req;
   logic        dma_we;
   logic [31:0] dma_address;
   logic [1:0]  dma_width;
   logic [3:0]  dma_len;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic        dma_done;
   logic        dma_starve;
   logic [31:0] mem_address;
   logic [1:0]  mem_width;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   int n_compared;
   int n_mismatched;

   logic        ram_init;
   logic [31:0] ram [0:255];
   logic [255:0] written;

   riscv_mem_arbiter #(.STARVE_LIMIT(16), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .core_address(core_address), .core_width(core_width), .core_wdata(core_wdata),
      .core_read(core_read), .core_write(core_write), .core_rdata(core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address), .dma_width(dma_width),
      .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_starve(dma_starve),
      .mem_address(mem_address), .mem_width(mem_width), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Unwritten words read back as 0xA5000000 | word index.
   always @(posedge clock) begin
      if (ram_init) begin
         written   <= '0;
         mem_rdata <= 32'd0;
      end else begin
         if (mem_write) begin
            ram[mem_address[9:2]]     <= mem_wdata;
            written[mem_address[9:2]] <= 1'b1;
         end
         if (mem_read) begin
            mem_rdata <= written[mem_address[9:2]] ? ram[mem_address[9:2]]
                                                   : (32'hA500_0000 | {24'd0, mem_address[9:2]});
         end
      end
   end

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic idle_inputs();
      core_address = 32'd0; core_width = 2'd0; core_wdata = 32'd0;
      core_read = 1'b0; core_write = 1'b0;
      dma_req = 1'b0; dma_we = 1'b0; dma_address = 32'd0; dma_width = 2'd0;
      dma_len = 4'd0; dma_wdata = 32'd0;
   endtask

   initial begin
      n_compared = 0;
      n_mismatched = 0;
      ram_init = 1'b1;
      reset = 1'b1;
      idle_inputs();
      #1;
      check_value("rst_gnt", dma_gnt, 1'b0);
      check_value("rst_rvalid", dma_rvalid, 1'b0);
      check_value("rst_done", dma_done, 1'b0);
      check_value("rst_starve", dma_starve, 1'b0);
      check_value("rst_rdata", dma_rdata, 32'd0);
      check_value("rst_mem_read", mem_read, 1'b0);
      check_value("rst_mem_addr", mem_address, 32'd0);
      step();
      step();
      ram_init = 1'b0;
      reset = 1'b0;
      step();

      // 1: core read wins, DMA read (width code 3) served next idle cycle
      core_read = 1'b1; core_address = 32'h100; core_width = 2'd2;
      dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'h200; dma_width = 2'd3;
      #1;
      check_value("t1_core_addr", mem_address, 32'h100);
      check_value("t1_core_read", mem_read, 1'b1);
      check_value("t1_gnt_blocked", dma_gnt, 1'b0);
      step();
      core_read = 1'b0;
      #1;
      check_value("t1_gnt", dma_gnt, 1'b1);
      check_value("t1_dma_addr", mem_address, 32'h200);
      check_value("t1_w3_word", mem_width, 2'd2);
      check_value("t1_done", dma_done, 1'b1);
      check_value("t1_core_rdata", core_rdata, 32'hA500_0040);
      step();
      dma_req = 1'b0;
      #1;
      check_value("t1_rvalid", dma_rvalid, 1'b1);
      check_value("t1_rdata", dma_rdata, 32'hA500_0080);
      check_value("t1_idle_read", mem_read, 1'b0);
      step();
      check_value("t1_rvalid_off", dma_rvalid, 1'b0);

      // 2: 20 back-to-back core reads starve the DMA
      dma_req = 1'b1; dma_address = 32'h208; dma_width = 2'd2;
      core_read = 1'b1; core_address = 32'h104;
      for (int k = 0; k < 20; k++) begin
         #1;
         check_value($sformatf("t2_starve_%0d", k), dma_starve, (k >= 16) ? 1'b1 : 1'b0);
         if (k == 2) check_value("t2_core_rdata", core_rdata, 32'hA500_0041);
         if (k == 5) check_value("t2_gnt_blocked", dma_gnt, 1'b0);
         step();
      end
      core_read = 1'b0;
      #1;
      check_value("t2_gnt", dma_gnt, 1'b1);
      check_value("t2_starve_at_gnt", dma_starve, 1'b1);
      step();
      dma_req = 1'b0;
      #1;
      check_value("t2_starve_clr", dma_starve, 1'b0);
      check_value("t2_rdata", dma_rdata, 32'hA500_0082);
      step();

      // 3: DMA write then core load of the same word
      dma_req = 1'b1; dma_we = 1'b1; dma_address = 32'h40; dma_wdata = 32'hDEAD_BEEF;
      #1;
      check_value("t3_gnt", dma_gnt, 1'b1);
      check_value("t3_mem_write", mem_write, 1'b1);
      check_value("t3_mem_read", mem_read, 1'b0);
      check_value("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      dma_req = 1'b0; dma_we = 1'b0;
      core_read = 1'b1; core_address = 32'h40; core_width = 2'd0;
      #1;
      check_value("t3_no_rvalid", dma_rvalid, 1'b0);
      check_value("t3_core_byte", mem_width, 2'd0);
      step();
      core_read = 1'b0;
      #1;
      check_value("t3_core_rdata", core_rdata, 32'hDEAD_BEEF);
      step();

      // 6: read+write together is a write, no read owner
      core_read = 1'b1; core_write = 1'b1; core_address = 32'h80; core_wdata = 32'h1234_5678;
      core_width = 2'd2;
      #1;
      check_value("t6_mem_write", mem_write, 1'b1);
      check_value("t6_mem_read", mem_read, 1'b0);
      step();
      core_write = 1'b0; core_read = 1'b1;
      #1;
      check_value("t6_rvalid", dma_rvalid, 1'b0);
      step();
      core_read = 1'b0;
      #1;
      check_value("t6_readback", core_rdata, 32'h1234_5678);
      step();

`ifdef ARB_BURST_EN
      // 4: wrapping 4-beat burst interleaved with core reads
      begin
         logic [31:0] exp_addr [0:3];
         exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
         exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
         dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'hFFFF_FFF8; dma_width = 2'd2; dma_len = 4'd3;
         core_address = 32'h0;
         for (int c = 0; c < 7; c++) begin
            core_read = (c % 2 == 1) ? 1'b1 : 1'b0;
            #1;
            check_value($sformatf("t4_gnt_%0d", c), dma_gnt, (c % 2 == 0) ? 1'b1 : 1'b0);
            check_value($sformatf("t4_done_%0d", c), dma_done, (c == 6) ? 1'b1 : 1'b0);
            if (c % 2 == 0) check_value($sformatf("t4_addr_%0d", c), mem_address, exp_addr[c/2]);
            if (c == 1) check_value("t4_rdata_b0", dma_rdata, 32'hA500_00FE);
            step();
         end
         core_read = 1'b0; dma_req = 1'b0; dma_len = 4'd0;
         #1;
         check_value("t4_gnt_after", dma_gnt, 1'b0);
         check_value("t4_rdata_b3", dma_rdata, 32'hA500_0001);
         step();
      end

      // 5: reset after the second beat of a burst
      dma_req = 1'b1; dma_address = 32'h300; dma_len = 4'd3;
      #1;
      check_value("t5_b0_addr", mem_address, 32'h300);
      step();
      #1;
      check_value("t5_b1_addr", mem_address, 32'h304);
      #1;
      reset = 1'b1;
      #1;
      check_value("t5_rst_gnt", dma_gnt, 1'b0);
      check_value("t5_rst_read", mem_read, 1'b0);
      check_value("t5_rst_addr", mem_address, 32'd0);
      check_value("t5_rst_done", dma_done, 1'b0);
      check_value("t5_rst_rvalid", dma_rvalid, 1'b0);
      dma_req = 1'b0;
      step();
      reset = 1'b0;
      #1;
      check_value("t5_post_gnt", dma_gnt, 1'b0);
      step();
      check_value("t5_post_done", dma_done, 1'b0);
      dma_req = 1'b1; dma_address = 32'h100; dma_len = 4'd0;
      #1;
      check_value("t5_new_addr", mem_address, 32'h100);
      check_value("t5_new_done", dma_done, 1'b1);
      step();
      dma_req = 1'b0;
      step();
`else
      // 4/5 single-beat build: dma_len ignored, reset aborts a pending request
      dma_req = 1'b1; dma_we = 1'b0; dma_address = 32'h300; dma_width = 2'd2; dma_len = 4'd3;
      #1;
      check_value("s4_gnt", dma_gnt, 1'b1);
      check_value("s4_done", dma_done, 1'b1);
      check_value("s4_addr", mem_address, 32'h300);
      step();
      #1;
      reset = 1'b1;
      #1;
      check_value("s5_rst_gnt", dma_gnt, 1'b0);
      check_value("s5_rst_read", mem_read, 1'b0);
      check_value("s5_rst_addr", mem_address, 32'd0);
      check_value("s5_rst_done", dma_done, 1'b0);
      check_value("s5_rst_rvalid", dma_rvalid, 1'b0);
      dma_req = 1'b0;
      step();
      reset = 1'b0;
      #1;
      check_value("s5_post_gnt", dma_gnt, 1'b0);
      step();
      check_value("s5_post_rvalid", dma_rvalid, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
